// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges the single-cycle pipeline (P)
// writeback with a buffered long-latency (L) result stream onto one
// registered write port. P normally wins; a starvation counter forces an
// L drain after STARVE_LIMIT consecutive P grants while L data waits.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_valid,
    input  logic [4:0]  p_rd,
    input  logic [31:0] p_data,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic [4:0]  l_rd,
    input  logic [31:0] l_data,
    output logic        p_stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t           mem_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wb_en_q;
    logic [4:0]    wb_rd_q;
    logic [31:0]   wb_data_q;

    logic nonempty, p_req, push, pop, grant_p, grant_l;
    wr_t  head;

    assign nonempty = (cnt_q != '0);
    assign head     = mem_q[rptr_q];
    // Gated by reset directly so l_ready is low in reset and high the
    // first cycle after release; a same-cycle pop never frees a full slot.
    assign l_ready  = rst && (cnt_q < CW'(FIFO_DEPTH));
    assign p_stall  = (starve_q == SW'(STARVE_LIMIT)) && nonempty;
    assign p_req    = p_valid && (p_rd != 5'd0);
    // Writes to x0 are handshaked but never stored.
    assign push     = l_valid && l_ready && (l_rd != 5'd0);
    assign grant_l  = p_stall || (!p_req && nonempty);
    assign grant_p  = !p_stall && p_req;
    assign pop      = grant_l;

    // Next buffer occupancy and starvation count
    always_comb begin
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        starve_d = '0;
        if (grant_p && nonempty)
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end

    // Buffer pointers, occupancy and starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Buffer storage; validity comes from the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= '{rd: l_rd, data: l_data};
    end

    // Registered write port; index/data hold when nothing is granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q <= grant_p || grant_l;
            if (grant_l) begin
                wb_rd_q   <= head.rd;
                wb_data_q <= head.data;
            end else if (grant_p) begin
                wb_rd_q   <= p_rd;
                wb_data_q <= p_data;
            end
        end
    end

    // Pending-write scoreboard: OR of rd decodes over live buffer entries
    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < cnt_q)
                busy = busy | (32'(1) << mem_q[rptr_q + AW'(i)].rd);
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int LIM = 4;
    localparam int DEP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_valid = 1'b0;
    logic [4:0]  p_rd = '0;
    logic [31:0] p_data = '0;
    logic        l_valid = 1'b0;
    logic        l_ready;
    logic [4:0]  l_rd = '0;
    logic [31:0] l_data = '0;
    logic        p_stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy;

    wb_port_arbiter #(.STARVE_LIMIT(LIM), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .p_stall(p_stall),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    int          starve = 0;
    logic        m_en   = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (q[i]) b[q[i].rd] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        starve = 0;
        m_en   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check port.
    task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        output logic p_done, output logic l_done);
        logic exp_lr, exp_st, preq, waiting;
        ent_t e;
        @(negedge clk);
        p_valid = pv; p_rd = prd; p_data = pd;
        l_valid = lv; l_rd = lrd; l_data = ld;
        #1;
        exp_lr  = (q.size() < DEP);
        exp_st  = (starve == LIM) && (q.size() > 0);
        chk("l_ready", 32'(l_ready), 32'(exp_lr));
        chk("p_stall", 32'(p_stall), 32'(exp_st));
        preq    = pv && (prd != 0);
        waiting = (q.size() > 0);
        if (exp_st || (!preq && waiting)) begin
            e = q.pop_front();
            m_en = 1'b1; m_rd = e.rd; m_data = e.data;
            starve = 0;
        end else if (preq) begin
            m_en = 1'b1; m_rd = prd; m_data = pd;
            starve = waiting ? ((starve < LIM) ? starve + 1 : LIM) : 0;
        end else begin
            m_en = 1'b0;
            starve = 0;
        end
        if (lv && exp_lr && lrd != 0) begin
            e.rd = lrd; e.data = ld;
            q.push_back(e);
        end
        p_done = !exp_st;
        l_done = lv && exp_lr;
        @(posedge clk);
        #1;
        chk("wb_en",   32'(wb_en), 32'(m_en));
        chk("wb_rd",   32'(wb_rd), 32'(m_rd));
        chk("wb_data", wb_data,    m_data);
        chk("busy",    busy,       m_busy());
    endtask

    task automatic idle(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a, b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb_en"},   32'(wb_en),   0);
        chk({tag, "_wb_rd"},   32'(wb_rd),   0);
        chk({tag, "_wb_data"}, wb_data,      0);
        chk({tag, "_busy"},    busy,         0);
        chk({tag, "_p_stall"}, 32'(p_stall), 0);
        chk({tag, "_l_ready"}, 32'(l_ready), 0);
    endtask

    initial begin
        logic pd_, ld_;
        logic        pv, lv;
        logic [4:0]  prd, lrd;
        logic [31:0] pdat, ldat;
        int          lq;

        // reset state
        repeat (3) @(negedge clk);
        chk_zero("rst");
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // P only, then x0 P write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, pd_, ld_);
        chk("p_only_data", wb_data, 32'hDEADBEEF);
        step(1, 0, 32'h12345678, 0, 0, 0, pd_, ld_);
        chk("p_x0_en", 32'(wb_en), 0);

        // collision: P wins, L drains next idle cycle
        step(1, 3, 32'hAAAA0003, 1, 7, 32'hBBBB0007, pd_, ld_);
        chk("coll_busy7", 32'(busy[7]), 1);
        step(0, 0, 0, 0, 0, 0, pd_, ld_);
        chk("coll_rd7", 32'(wb_rd), 7);
        chk("coll_busy7_clr", 32'(busy[7]), 0);

        // starvation: rd=9 waits behind a continuous P stream
        step(1, 1, 32'h100, 1, 9, 32'h99, pd_, ld_);
        for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'(i), 0, 0, 0, pd_, ld_);
        step(1, 20, 32'h2020, 0, 0, 0, pd_, ld_);
        chk("starve_stalled", 32'(pd_), 0);
        chk("starve_rd9", 32'(wb_rd), 9);
        step(1, 20, 32'h2020, 0, 0, 0, pd_, ld_);
        chk("starve_held_p", 32'(wb_rd), 20);

        // full buffer: three L offers with P busy, third held until a pop
        lq = 0;
        for (int i = 0; i < 12 && lq < 3; i++) begin
            step(1, 5'(1 + i), 32'(i), 1, 5'(21 + lq), 32'(lq), pd_, ld_);
            if (i == 2) chk("full_l_ready", 32'(l_ready), 0);
            if (ld_) lq++;
        end
        idle(4);

        // L to x0 is accepted and dropped
        step(0, 0, 0, 1, 0, 32'hFFFF, pd_, ld_);
        chk("x0_accept", 32'(ld_), 1);
        chk("x0_busy", busy, 0);
        idle(2);

        // reset mid-operation with two buffered entries
        step(1, 4, 1, 1, 11, 32'h11, pd_, ld_);
        step(1, 4, 2, 1, 12, 32'h12, pd_, ld_);
        chk("pre_rst_busy", busy, 32'h0000_1800);
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        model_reset();
        p_valid = 0; l_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        // randomized traffic, two load mixes
        pv = 0; lv = 0; prd = 0; lrd = 0; pdat = 0; ldat = 0;
        pd_ = 1; ld_ = 1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                if (pd_ || !pv) begin
                    pv   = ($urandom_range(0, 9) < (ph == 0 ? 9 : 4));
                    prd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pdat = $urandom;
                end
                if (ld_ || !lv) begin
                    lv   = ($urandom_range(0, 9) < 4);
                    lrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    ldat = $urandom;
                end
                step(pv, prd, pdat, lv, lrd, ldat, pd_, ld_);
            end
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
